// File: rtl/maxunpooling_2.sv
// 2x2 max-unpooling upsampler: streams pooled samples in, emits a 2*IN_DIM square map per channel.
// Optional UNPOOL_INDEX_EN: place each sample only at its stored argmax position and output 0 elsewhere.
module maxunpooling_2 #(
  parameter int bitwidth = 8,
  parameter int CHANNELS = 2,
  parameter int IN_DIM   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [bitwidth-1:0] in_data,
  input  logic [1:0]                 in_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [bitwidth-1:0] out_data,
  output logic                       out_last,
  output logic                       out_frame_last
);
  localparam int OUT_DIM = 2 * IN_DIM;
  localparam int CW = $clog2(OUT_DIM);
  localparam int HW = $clog2((CHANNELS > 1) ? CHANNELS : 2);
  localparam logic [CW-1:0] LAST_POS = CW'(OUT_DIM - 1);
  localparam logic [HW-1:0] LAST_CH  = HW'(CHANNELS - 1);

  typedef enum logic {EVEN, ODD} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_run;
  logic                       r_hold_vld;
  logic signed [bitwidth-1:0] r_hold_dat;
  logic signed [bitwidth-1:0] r_lb [IN_DIM];
  logic [CW-1:0]              r_row, r_col, w_row_nxt, w_col_nxt;
  logic [HW-1:0]              r_ch, w_ch_nxt;
  logic                       r_out_vld, r_out_last, r_out_flast;
  logic signed [bitwidth-1:0] r_out_dat;

  logic                       w_out_take, w_in_rdy, w_in_fire, w_emit;
  logic                       w_col_end, w_row_end, w_ch_end;
  logic signed [bitwidth-1:0] w_src, w_emit_dat;

`ifdef UNPOOL_INDEX_EN
  logic [1:0] r_hold_idx;
  logic [1:0] r_lb_idx [IN_DIM];
  logic [1:0] w_src_idx;
`else
  logic w_unused_idx;
  assign w_unused_idx = ^in_idx;
`endif

  assign w_out_take = !r_out_vld || out_ready;
  assign w_in_rdy   = r_run && (r_state == EVEN) && !r_hold_vld && w_out_take;
  assign w_in_fire  = in_valid && w_in_rdy;
  assign w_col_end  = (r_col == LAST_POS);
  assign w_row_end  = (r_row == LAST_POS);
  assign w_ch_end   = (r_ch == LAST_CH);

  // Source of the next output: line buffer in ODD, else the held sample (col 2j+1) or the fresh input (col 2j)
  always_comb begin
    w_emit = 1'b0;
    w_src  = r_hold_dat;
`ifdef UNPOOL_INDEX_EN
    w_src_idx = r_hold_idx;
`endif
    if (r_state == ODD) begin
      w_emit = w_out_take;
      w_src  = r_lb[r_col[CW-1:1]];
`ifdef UNPOOL_INDEX_EN
      w_src_idx = r_lb_idx[r_col[CW-1:1]];
`endif
    end else if (r_hold_vld) begin
      w_emit = w_out_take;
    end else if (w_in_fire) begin
      w_emit = 1'b1;
      w_src  = in_data;
`ifdef UNPOOL_INDEX_EN
      w_src_idx = in_idx;
`endif
    end
`ifdef UNPOOL_INDEX_EN
    w_emit_dat = (w_src_idx == {r_col[0], r_row[0]}) ? w_src : '0;
`else
    w_emit_dat = w_src;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_ch_nxt    = r_ch;
    if (w_emit) begin
      if (w_col_end) begin
        w_col_nxt   = '0;
        w_state_nxt = (r_state == EVEN) ? ODD : EVEN;
        if (w_row_end) begin
          w_row_nxt = '0;
          w_ch_nxt  = w_ch_end ? '0 : r_ch + 1'b1;
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EVEN;
      r_row   <= '0;
      r_col   <= '0;
      r_ch    <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_ch    <= w_ch_nxt;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld <= 1'b0;
      r_hold_dat <= '0;
    end else if (w_in_fire) begin
      r_hold_vld <= 1'b1;
      r_hold_dat <= in_data;
    end else if ((r_state == EVEN) && r_hold_vld && w_out_take) begin
      r_hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_lb[r_col[CW-1:1]] <= in_data;
    end
  end

`ifdef UNPOOL_INDEX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold_idx <= '0;
    else if (w_in_fire) r_hold_idx <= in_idx;
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_lb_idx[r_col[CW-1:1]] <= in_idx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_out_last  <= 1'b0;
      r_out_flast <= 1'b0;
    end else if (w_emit) begin
      r_out_vld   <= 1'b1;
      r_out_dat   <= w_emit_dat;
      r_out_last  <= w_col_end && w_row_end;
      r_out_flast <= w_col_end && w_row_end && w_ch_end;
    end else if (out_ready) begin
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_flast <= 1'b0;
    end
  end

  assign in_ready       = w_in_rdy;
  assign out_valid      = r_out_vld;
  assign out_data       = r_out_dat;
  assign out_last       = r_out_last;
  assign out_frame_last = r_out_flast;
endmodule
